// File: rtl/io_uart_pkg.sv
// Shared definitions for the io-bus UART transmitter: FSM encoding,
// register offsets and status bit positions.
package io_uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // Register offsets relative to BASE_ADDR (8-bit, so the sum wraps).
    localparam logic [7:0] DATA_OFS = 8'd0;
    localparam logic [7:0] STAT_OFS = 8'd1;

    // Status register bit positions.
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    // Baud counter width; covers CLKS_PER_BIT up to 65535.
    localparam int BAUD_W = 16;

endpackage

// File: rtl/io_uart_tx_if.sv
// CPU io-bus signals seen by an io-space responder. The master side is the
// CPU (or a testbench standing in for it); the slave side is the peripheral.
interface io_uart_tx_if;

    logic [7:0] i_bus;        // write data from the CPU
    logic [7:0] o_bus;        // read data to the tristate net, 8'h00 when idle
    logic       o_busNOE;     // active-low output enable for o_bus
    logic       i_ioSelect;   // io space qualifier
    logic [7:0] i_ioAddress;  // io register address
    logic       i_ioNOE;      // active-low read strobe
    logic       i_ioNWE;      // active-low write strobe

    modport master (
        output i_bus, i_ioSelect, i_ioAddress, i_ioNOE, i_ioNWE,
        input  o_bus, o_busNOE
    );

    modport slave (
        input  i_bus, i_ioSelect, i_ioAddress, i_ioNOE, i_ioNWE,
        output o_bus, o_busNOE
    );

endinterface

// File: rtl/io_uart_fifo.sv
// Synchronous FIFO with first-word-fall-through head. A push while full is
// accepted only when a pop happens in the same cycle; otherwise it is dropped
// and the caller decides what to do about it.
module io_uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_head  = mem_q[rd_ptr_q];
    assign pop_ok  = i_pop && !o_empty;
    assign push_ok = i_push && (!o_full || pop_ok);

    // Next pointer and occupancy from the accepted push/pop pair.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    // NOTE: the storage is deliberately not reset; the pointers and count
    // define which entries are valid, and leaving it unreset keeps it a RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_push_data;
    end

endmodule

// File: rtl/io_uart_tx.sv
// io-bus UART transmitter. The CPU writes bytes to the data register, which
// queue in a FIFO; a serial engine sends them as 8N1 frames with no gap
// between queued bytes. The status register reports full/empty/busy/overflow.
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR    = 8'h10,
    parameter int         CLKS_PER_BIT = 868,
    parameter int         FIFO_DEPTH   = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    io_uart_tx_if.slave bus,
    output logic        o_uartTx,
    output logic        o_txBusy
);

    localparam logic [7:0]        DATA_ADDR = BASE_ADDR + DATA_OFS;
    localparam logic [7:0]        STAT_ADDR = BASE_ADDR + STAT_OFS;
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

    logic hit_data, hit_stat, rd_en, wr_data, wr_stat;
    logic [7:0] status;

    logic       fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_head;

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;

    // Address decode, status assembly and the combinational read path.
    always_comb begin
        hit_data = bus.i_ioSelect && (bus.i_ioAddress == DATA_ADDR);
        hit_stat = bus.i_ioSelect && (bus.i_ioAddress == STAT_ADDR);
        rd_en    = (hit_data || hit_stat) && !bus.i_ioNOE;
        wr_data  = hit_data && !bus.i_ioNWE;
        wr_stat  = hit_stat && !bus.i_ioNWE;

        status           = 8'h00;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_BUSY]  = busy_q;
        status[ST_OVF]   = ovf_q;

        bus.o_busNOE = !rd_en;
        // Data register reads as zero; only the status register returns data.
        bus.o_bus    = (rd_en && hit_stat) ? status : 8'h00;
    end

    io_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (i_clk),
        .rst         (i_reset),
        .i_push      (wr_data),
        .i_push_data (bus.i_bus),
        .i_pop       (fifo_pop),
        .o_head      (fifo_head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    // Sticky overflow: set by a dropped push, cleared by writing bit3 of status.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_data && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end else if (wr_stat && bus.i_bus[ST_OVF]) begin
            ovf_d = 1'b0;
        end
    end

    // Serial engine: next state, baud/bit counters, shift register and line.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    baud_d   = BAUD_LOAD;
                    state_d  = S_START;
                    tx_d     = 1'b0;
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    baud_d  = BAUD_LOAD;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_q == '0) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next frame with no idle gap.
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        baud_d   = BAUD_LOAD;
                        state_d  = S_START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Engine and control registers; reset forces the line high at once.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_uartTx = tx_q;
    assign o_txBusy = busy_q;

endmodule
